uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  UART receive frame sequencer; drives the Rx error-check datapath.
//  Oversamples RxSerial and walks the frame: start, data LSB-first, optional parity, stop.
//  Holds the captured fields stable, waits for the error checker to settle, then latches
//  its 3-bit flag and pulses Done. Sits between the baud generator and the error checker.
// PARAMETERS
//  OVERSAMPLE     16  BaudTick pulses per bit; even, >=4
//  DATA_BITS       8  data bits per frame (RawData width)
//  SETTLE_CYCLES   2  clocks in CHECK before ErrorFlagIn is latched; >=1
// PORTS
//  Clock         in   1          single clock for all state
//  Reset         in   1          asynchronous, active-high
//  BaudTick      in   1          one-Clock-wide oversample strobe
//  RxSerial      in   1          serial line, idle high, already synchronised
//  ParityType    in   2          01 odd, 10 even, 00/11 none
//  ErrorFlagIn   in   3          from checker: [0] parity, [1] start, [2] stop
//  RawData       out  DATA_BITS  captured data
//  ParityBit     out  1          captured parity bit; 1 when no parity
//  StartBit      out  1          captured start-bit sample
//  StopBit       out  1          captured stop-bit sample
//  ErrorFlagOut  out  3          ErrorFlagIn latched at end of CHECK
//  Done          out  1          one-Clock pulse: frame complete, ErrorFlagOut valid
//  Busy          out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: IDLE, tick/bit counters 0, RawData 0, ParityBit 1, StartBit 0, StopBit 1,
//   ErrorFlagOut 000, Done 0, Busy 0, prev-line reg 1. Reset mid-frame aborts; no Done.
//  Tick counter advances only on BaudTick; bit sample taken on BaudTick at sample point.
//  IDLE: prev-line 1 and RxSerial 0 -> START, tick count 0, latch ParityType.
//   ParityType changes mid-frame are ignored.
//  START: sample at tick OVERSAMPLE/2-1. Sample 1 -> IDLE (false start): no field update,
//   no Done. Sample 0 -> StartBit 0, DATA, counters 0.
//  DATA: sample every OVERSAMPLE ticks (count OVERSAMPLE-1, then wrap to 0);
//   bit n -> RawData[n], n = 0..DATA_BITS-1. RawData is written in place, not cleared at start.
//  After last bit: latched type 01/10 -> PARITY; otherwise -> STOP with ParityBit forced to 1.
//  PARITY: one bit period, sample -> ParityBit, then STOP.
//  STOP: one bit period, sample -> StopBit. Bad stop (0) still proceeds to CHECK;
//   the checker flags it.
//  CHECK: fields frozen; wait SETTLE_CYCLES Clocks, then ErrorFlagOut <= ErrorFlagIn,
//   Done = 1 for one Clock, -> IDLE.
//  Done is asserted the Clock after CHECK's last cycle.
//  A falling edge is recognised in IDLE only; a line already low on IDLE entry does not
//   start a frame until it has been seen high.
//  Latency: stop sample -> Done = SETTLE_CYCLES+1 Clocks.
//  Fields and ErrorFlagOut hold their values until overwritten by the next frame.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of RxSerial on the
//   sample-point BaudTick and the two preceding BaudTicks. Sample point and latency are
//   unchanged. This also applies to the false-start check.
//  Undefined: the single RxSerial value at the sample-point BaudTick is used.
// TESTING
//  Reset asserted mid-DATA -> Busy 0 next Clock, all outputs at reset values, no Done.
//  Even type, data 0xA5, parity 0, stop 1 -> RawData A5, ParityBit 0, ErrorFlagOut 000,
//   one Done pulse.
//  Type 00, data 0x3C, stop 0 -> ParityBit 1, StopBit 0, ErrorFlagOut 100 (checker model).
//   Frame is 10 bit periods.
//  Line low for 3 BaudTicks, then high -> false start, Busy falls, Done never pulses,
//   fields unchanged.
//  Odd type, data 0x01, parity 0; ParityType switched to 00 mid-DATA -> PARITY state still
//   entered, ErrorFlagOut 000.
//  With UART_RX_MAJORITY_EN: 1-tick low glitch at bit-3 sample point of data 0xFF ->
//   RawData FF. Without the macro the same stimulus gives F7.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_frame_ctrl
// Brief    : UART receive frame sequencer. Oversamples RxSerial, walks
//            start / data / optional parity / stop, then settles and latches
//            the error checker flags. Optional macro: UART_RX_MAJORITY_EN
//            (2-of-3 majority vote of the last three BaudTick samples).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_frame_ctrl #(
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 BaudTick,
  input  logic                 RxSerial,
  input  logic [1:0]           ParityType,
  input  logic [2:0]           ErrorFlagIn,
  output logic [DATA_BITS-1:0] RawData,
  output logic                 ParityBit,
  output logic                 StartBit,
  output logic                 StopBit,
  output logic [2:0]           ErrorFlagOut,
  output logic                 Done,
  output logic                 Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [TW-1:0] TICK_HALF   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_CHECK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [DATA_BITS-1:0] raw_q, raw_d;
  logic                 parity_q, parity_d;
  logic                 start_q, start_d;
  logic                 stop_q, stop_d;
  logic [2:0]           err_q, err_d;
  logic                 done_q, done_d;
  logic                 prev_q, prev_d;
  logic                 par_en_q, par_en_d;
  logic                 sample_bit;

`ifdef UART_RX_MAJORITY_EN
  // Line values seen on the two BaudTicks before the current one.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (BaudTick) begin
      hist_d = {hist_q[0], RxSerial};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign sample_bit = (RxSerial & hist_q[0]) | (RxSerial & hist_q[1]) |
                      (hist_q[0] & hist_q[1]);
`else
  assign sample_bit = RxSerial;
`endif

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    settle_d = settle_q;
    raw_d    = raw_q;
    parity_d = parity_q;
    start_d  = start_q;
    stop_d   = stop_q;
    err_d    = err_q;
    done_d   = 1'b0;
    prev_d   = RxSerial;
    par_en_d = par_en_q;

    case (state_q)
      S_IDLE: begin
        if (prev_q && !RxSerial) begin
          state_d  = S_START;
          tick_d   = '0;
          par_en_d = (ParityType == 2'b01) || (ParityType == 2'b10);
        end
      end

      S_START: begin
        if (BaudTick) begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            if (sample_bit) begin
              state_d = S_IDLE;
            end else begin
              start_d = 1'b0;
              bit_d   = '0;
              state_d = S_DATA;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (BaudTick) begin
          if (tick_q == TICK_LAST) begin
            tick_d       = '0;
            raw_d[bit_q] = sample_bit;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              if (par_en_q) begin
                state_d = S_PARITY;
              end else begin
                parity_d = 1'b1;
                state_d  = S_STOP;
              end
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (BaudTick) begin
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            parity_d = sample_bit;
            state_d  = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (BaudTick) begin
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            stop_d   = sample_bit;
            settle_d = '0;
            state_d  = S_CHECK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_CHECK: begin
        // Fields stay frozen while the external checker settles.
        if (settle_q == SETTLE_LAST) begin
          err_d    = ErrorFlagIn;
          done_d   = 1'b1;
          settle_d = '0;
          state_d  = S_IDLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      settle_q <= '0;
      raw_q    <= '0;
      parity_q <= 1'b1;
      start_q  <= 1'b0;
      stop_q   <= 1'b1;
      err_q    <= 3'b000;
      done_q   <= 1'b0;
      prev_q   <= 1'b1;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      settle_q <= settle_d;
      raw_q    <= raw_d;
      parity_q <= parity_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
      done_q   <= done_d;
      prev_q   <= prev_d;
      par_en_q <= par_en_d;
    end
  end

  assign RawData      = raw_q;
  assign ParityBit    = parity_q;
  assign StartBit     = start_q;
  assign StopBit      = stop_q;
  assign ErrorFlagOut = err_q;
  assign Done         = done_q;
  assign Busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_frame_ctrl
// Brief    : Scoreboard bench for uart_rx_frame_ctrl with a behavioural
//            error-checker model driving ErrorFlagIn.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_frame_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       BaudTick = 1'b0;
  logic       RxSerial = 1'b1;
  logic [1:0] ParityType = 2'b00;
  logic [2:0] ErrorFlagIn;
  logic [7:0] RawData;
  logic       ParityBit, StartBit, StopBit, Done, Busy;
  logic [2:0] ErrorFlagOut;

  logic [1:0] chk_ptype = 2'b00;

  typedef struct packed {
    logic [7:0] raw;
    logic       par;
    logic       start;
    logic       stop;
    logic [2:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  uart_rx_frame_ctrl #(
    .OVERSAMPLE   (16),
    .DATA_BITS    (8),
    .SETTLE_CYCLES(2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BaudTick    (BaudTick),
    .RxSerial    (RxSerial),
    .ParityType  (ParityType),
    .ErrorFlagIn (ErrorFlagIn),
    .RawData     (RawData),
    .ParityBit   (ParityBit),
    .StartBit    (StartBit),
    .StopBit     (StopBit),
    .ErrorFlagOut(ErrorFlagOut),
    .Done        (Done),
    .Busy        (Busy)
  );

  initial forever #5 Clock = ~Clock;

  // One-clock BaudTick every fourth clock.
  initial forever begin
    repeat (3) @(posedge Clock);
    #1 BaudTick = 1'b1;
    @(posedge Clock);
    #1 BaudTick = 1'b0;
  end

  // Error checker model: [0] parity, [1] start, [2] stop.
  always_comb begin
    ErrorFlagIn    = 3'b000;
    ErrorFlagIn[1] = StartBit;
    ErrorFlagIn[2] = ~StopBit;
    if (chk_ptype == 2'b01) ErrorFlagIn[0] = ~(^{RawData, ParityBit});
    if (chk_ptype == 2'b10) ErrorFlagIn[0] = ^{RawData, ParityBit};
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  // Monitor: every Done pulse is compared against the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge Clock);
    if (Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("raw_data", 32'(RawData), 32'(e.raw));
        check("parity_bit", 32'(ParityBit), 32'(e.par));
        check("start_bit", 32'(StartBit), 32'(e.start));
        check("stop_bit", 32'(StopBit), 32'(e.stop));
        check("error_flag", 32'(ErrorFlagOut), 32'(e.err));
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge Clock); while (BaudTick !== 1'b1);
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    if (glitch) begin
      #1 RxSerial = 1'b1;
      wait_ticks(7);
      #1 RxSerial = 1'b0;
      wait_ticks(1);
      #1 RxSerial = 1'b1;
      wait_ticks(8);
    end else begin
      #1 RxSerial = v;
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] ptype,
                            input logic par, input logic stop,
                            input int glitch_bit, input bit switch_mid);
    int n;
    #1 ParityType = ptype;
    chk_ptype = ptype;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(data[i], glitch_bit == i);
      if (i == 0) begin
        #1 check("busy_mid_frame", 32'(Busy), 32'd1);
      end
      if (switch_mid && i == 4) begin
        #1 ParityType = 2'b00;
      end
    end
    if (ptype == 2'b01 || ptype == 2'b10) drive_bit(par, 1'b0);
    drive_bit(stop, 1'b0);
    #1 RxSerial = 1'b1;
    wait_ticks(4);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge Clock);
      n++;
    end
    check("done_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1 Reset = 1'b1;
    #2;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_raw", 32'(RawData), 32'h00);
    check("rst_parity", 32'(ParityBit), 32'd1);
    check("rst_start", 32'(StartBit), 32'd0);
    check("rst_stop", 32'(StopBit), 32'd1);
    check("rst_err", 32'(ErrorFlagOut), 32'd0);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    wait_ticks(2);

    // Even parity, 0xA5 (four ones) with parity 0: clean frame.
    exp_q.push_back('{raw: 8'hA5, par: 1'b0, start: 1'b0, stop: 1'b1, err: 3'b000});
    send_frame(8'hA5, 2'b10, 1'b0, 1'b1, -1, 1'b0);

    // No parity, 0x3C, bad stop bit: stop error flagged.
    exp_q.push_back('{raw: 8'h3C, par: 1'b1, start: 1'b0, stop: 1'b0, err: 3'b100});
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, -1, 1'b0);

    // False start: low for three ticks only.
    #1 RxSerial = 1'b0;
    wait_ticks(3);
    #1 RxSerial = 1'b1;
    wait_ticks(12);
    #1;
    check("fs_busy", 32'(Busy), 32'd0);
    check("fs_raw", 32'(RawData), 32'h3C);
    check("fs_parity", 32'(ParityBit), 32'd1);
    check("fs_start", 32'(StartBit), 32'd0);
    check("fs_stop", 32'(StopBit), 32'd0);
    check("fs_err", 32'(ErrorFlagOut), 32'b100);

    // Odd parity, 0x01 with parity 0; type changed to none mid-frame.
    exp_q.push_back('{raw: 8'h01, par: 1'b0, start: 1'b0, stop: 1'b1, err: 3'b000});
    send_frame(8'h01, 2'b01, 1'b0, 1'b1, -1, 1'b1);

    // 0xFF with a one-tick low glitch on the bit-3 sample point.
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back('{raw: 8'hFF, par: 1'b1, start: 1'b0, stop: 1'b1, err: 3'b000});
`else
    exp_q.push_back('{raw: 8'hF7, par: 1'b1, start: 1'b0, stop: 1'b1, err: 3'b000});
`endif
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 3, 1'b0);

    // Reset during DATA aborts the frame.
    #1 ParityType = 2'b00;
    chk_ptype = 2'b00;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    wait_ticks(3);
    #1 Reset = 1'b1;
    RxSerial = 1'b1;
    #1;
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_raw", 32'(RawData), 32'h00);
    check("mid_rst_parity", 32'(ParityBit), 32'd1);
    check("mid_rst_start", 32'(StartBit), 32'd0);
    check("mid_rst_stop", 32'(StopBit), 32'd1);
    check("mid_rst_err", 32'(ErrorFlagOut), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    wait_ticks(40);
    #1 check("post_rst_busy", 32'(Busy), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
